// File: rtl/fifo_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_uart_tx : pops bytes from an 8-bit synchronous FIFO and sends each  |
// |                one as a UART frame (start, 8 data LSB-first, [even      |
// |                parity], 1 or 2 stop bits).                              |
// | Revision     : 1.0 - initial release                                     |
// +--------------------------------------------------------------------------+
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_fifo_empty,
  output logic       o_fifo_rd_en,
  input  logic [7:0] i_fifo_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_frame_done
);

  // One spare bit so the counter also spans two stop bits.
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CW-1:0] c_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_STOP_PRE  = CW'(STOP_BITS * CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic            r_tx;
  logic            r_busy;
  logic            r_frame_done;

  // The pop must reach the FIFO in the IDLE cycle itself so its registered
  // data_out is valid during FETCH; reset gates it so no byte is lost to reset.
  assign o_fifo_rd_en = (r_state == S_IDLE) && !i_fifo_empty && !reset;

  assign o_tx         = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (!i_fifo_empty) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_shift   <= i_fifo_data;
          r_parity  <= ^i_fifo_data;
          r_bit_idx <= '0;
          r_baud    <= '0;
          r_tx      <= 1'b0;
          r_state   <= S_START;
        end
        S_START: begin
          if (r_baud == c_BIT_LAST) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_DATA: begin
          if (r_baud == c_BIT_LAST) begin
            r_baud    <= '0;
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_tx <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_PARITY: begin
          if (r_baud == c_BIT_LAST) begin
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_baud <= r_baud + CW'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (r_baud == c_STOP_LAST) begin
            r_baud       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_baud       <= r_baud + CW'(1);
            r_frame_done <= (r_baud == c_STOP_PRE);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
